// File: rtl/xadc_drp_sequencer.sv
// Round-robin XADC DRP read sequencer: one aux-channel read per end-of-conversion.
// Define XADC_SEQ_AVG_EN to average 16 reads per channel before publishing.
module xadc_drp_sequencer #(
    parameter logic [6:0] ADDR0   = 7'h1E,
    parameter logic [6:0] ADDR1   = 7'h17,
    parameter logic [6:0] ADDR2   = 7'h1F,
    parameter logic [6:0] ADDR3   = 7'h16,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ch_en,
    input  logic        eoc,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [47:0] sample_flat,
    output logic [3:0]  sample_valid,
    output logic [1:0]  cur_ch,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t      state, state_n;
    logic [1:0]  ptr;
    logic [1:0]  sel;
    logic [7:0]  timer;
    logic [11:0] s [4];
    logic        load, rd_done, tmo;
    logic        unused_lo;

    assign unused_lo   = ^drp_do[3:0];
    assign sample_flat = {s[3], s[2], s[1], s[0]};

    function automatic logic [6:0] addr_of(input logic [1:0] c);
        logic [6:0] a;
        unique case (c)
            2'd0:    a = ADDR0;
            2'd1:    a = ADDR1;
            2'd2:    a = ADDR2;
            default: a = ADDR3;
        endcase
        return a;
    endfunction

    // First enabled channel at or after ptr, wrapping
    always_comb begin
        logic       found;
        logic [1:0] idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && ch_en[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        drp_den = 1'b0;
        busy    = 1'b0;
        load    = 1'b0;
        rd_done = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (eoc && |ch_en) begin
                    load    = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                drp_den = 1'b1;
                busy    = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (drp_drdy) begin
                    rd_done = 1'b1;
                    state_n = S_IDLE;
                end else if (timer == TIMEOUT) begin
                    tmo     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef XADC_SEQ_AVG_EN
    logic [15:0] acc [4];
    logic [3:0]  cnt [4];
    logic [15:0] acc_sum [4];

    always_comb begin
        for (int i = 0; i < 4; i++)
            acc_sum[i] = acc[i] + {4'd0, drp_do[15:4]};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= 2'd0;
            cur_ch       <= 2'd0;
            drp_daddr    <= ADDR0;
            timer        <= 8'd0;
            timeout_err  <= 1'b0;
            sample_valid <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                s[i] <= 12'd0;
`ifdef XADC_SEQ_AVG_EN
                acc[i] <= 16'd0;
                cnt[i] <= 4'd0;
`endif
            end
        end else begin
            if (load) begin
                cur_ch    <= sel;
                drp_daddr <= addr_of(sel);
            end
            if (state == S_ISSUE)     timer <= 8'd0;
            else if (state == S_WAIT) timer <= timer + 8'd1;
            if (rd_done || tmo) ptr <= cur_ch + 2'd1;
            if (tmo) timeout_err <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                sample_valid[i] <= 1'b0;
                // Disable wins over an in-flight result
                if (!ch_en[i]) begin
                    s[i] <= 12'd0;
`ifdef XADC_SEQ_AVG_EN
                    acc[i] <= 16'd0;
                    cnt[i] <= 4'd0;
`endif
                end else if (rd_done && cur_ch == 2'(i)) begin
`ifdef XADC_SEQ_AVG_EN
                    if (cnt[i] == 4'hF) begin
                        s[i]            <= acc_sum[i][15:4];
                        sample_valid[i] <= 1'b1;
                        acc[i]          <= 16'd0;
                        cnt[i]          <= 4'd0;
                    end else begin
                        acc[i] <= acc_sum[i];
                        cnt[i] <= cnt[i] + 4'd1;
                    end
`else
                    s[i]            <= drp_do[15:4];
                    sample_valid[i] <= 1'b1;
`endif
                end
`ifdef XADC_SEQ_AVG_EN
                else if (tmo && cur_ch == 2'(i)) begin
                    acc[i] <= 16'd0;
                    cnt[i] <= 4'd0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer: round-robin, sparse enable,
// timeout, overlap, async reset, and (with XADC_SEQ_AVG_EN) averaging.
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ch_en;
    logic        eoc;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic [47:0] sample_flat;
    logic [3:0]  sample_valid;
    logic [1:0]  cur_ch;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int den_cnt = 0;
    int v0_cnt = 0;

    always #5 clk = ~clk;

    xadc_drp_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .eoc          (eoc),
        .drp_den      (drp_den),
        .drp_daddr    (drp_daddr),
        .drp_do       (drp_do),
        .drp_drdy     (drp_drdy),
        .sample_flat  (sample_flat),
        .sample_valid (sample_valid),
        .cur_ch       (cur_ch),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always @(posedge clk) begin
        if (drp_den)         den_cnt <= den_cnt + 1;
        if (sample_valid[0]) v0_cnt  <= v0_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // eoc, den check, drdy three cycles after den, sample check
    task automatic do_read(input logic [6:0] addr, input int ch,
                           input logic [15:0] data);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("den", 64'(drp_den), 64'd1);
        chk("daddr", 64'(drp_daddr), 64'(addr));
        tick();
        tick();
        tick();
        drp_drdy = 1'b1;
        drp_do   = data;
        tick();
        drp_drdy = 1'b0;
`ifndef XADC_SEQ_AVG_EN
        chk("valid", 64'(sample_valid), 64'(4'b0001 << ch));
        chk("sample", 64'(sample_flat[ch*12 +: 12]), 64'(data[15:4]));
`endif
        tick();
`ifndef XADC_SEQ_AVG_EN
        chk("valid_clr", 64'(sample_valid), 64'd0);
`endif
    endtask

    initial begin
        int d0;
        logic [11:0] s0_keep;
        logic [6:0]  rr_addr [4];
        rr_addr[0] = 7'h1E;
        rr_addr[1] = 7'h17;
        rr_addr[2] = 7'h1F;
        rr_addr[3] = 7'h16;

        rst_n    = 1'b0;
        ch_en    = 4'd0;
        eoc      = 1'b0;
        drp_do   = 16'd0;
        drp_drdy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_den", 64'(drp_den), 64'd0);
        chk("rst_daddr", 64'(drp_daddr), 64'h1E);
        chk("rst_flat", sample_flat, 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur", 64'(cur_ch), 64'd0);

        // Round-robin over all four channels, twice
        ch_en = 4'b1111;
        tick();
        for (int r = 0; r < 8; r++) begin
            logic [15:0] d;
            d = (r % 4 == 2) ? 16'hABC0 : 16'(16'h1000 * (r + 1) + 16'h0120);
            do_read(rr_addr[r % 4], r % 4, d);
            chk("rr_cur", 64'(cur_ch), 64'(r % 4));
        end

        // Sparse enable: ch0 and ch3 only
        ch_en = 4'b1001;
        tick();
        do_read(7'h1E, 0, 16'h2220);
        do_read(7'h16, 3, 16'h3330);
        do_read(7'h1E, 0, 16'h4440);
        do_read(7'h16, 3, 16'h5550);
        chk("sparse_clr", 64'(sample_flat[35:12]), 64'd0);

        // No enabled channel: eoc ignored
        ch_en = 4'b0000;
        d0    = den_cnt;
        eoc   = 1'b1;
        tick();
        eoc = 1'b0;
        repeat (5) tick();
        chk("noen_den", 64'(den_cnt - d0), 64'd0);
        chk("noen_busy", 64'(busy), 64'd0);
        chk("noen_flat", sample_flat, 64'd0);

        // Timeout on ch0, 256 WAIT cycles without drdy
        ch_en = 4'b0001;
        tick();
        do_read(7'h1E, 0, 16'h6660);
        s0_keep = sample_flat[11:0];
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("to_den", 64'(drp_den), 64'd1);
        chk("to_daddr", 64'(drp_daddr), 64'h1E);
        repeat (256) tick();
        chk("to_busy_pre", 64'(busy), 64'd1);
        chk("to_terr_pre", 64'(timeout_err), 64'd0);
        tick();
        chk("to_terr", 64'(timeout_err), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_s0", 64'(sample_flat[11:0]), 64'(s0_keep));
        chk("to_valid", 64'(sample_valid), 64'd0);
        do_read(7'h1E, 0, 16'h7770);
        chk("to_sticky", 64'(timeout_err), 64'd1);

        // eoc during WAIT is dropped; ptr is 1 here
        ch_en = 4'b1111;
        tick();
        d0  = den_cnt;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("ov_daddr", 64'(drp_daddr), 64'h17);
        tick();
        tick();
        eoc = 1'b1;
        tick();
        eoc      = 1'b0;
        drp_drdy = 1'b1;
        drp_do   = 16'h8880;
        tick();
        drp_drdy = 1'b0;
`ifndef XADC_SEQ_AVG_EN
        chk("ov_s1", 64'(sample_flat[23:12]), 64'h888);
`endif
        repeat (3) tick();
        chk("ov_dens", 64'(den_cnt - d0), 64'd1);
        chk("ov_busy", 64'(busy), 64'd0);

        // Async reset while in WAIT, then a late drdy
        d0  = den_cnt;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("ar_daddr", 64'(drp_daddr), 64'h1F);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_daddr0", 64'(drp_daddr), 64'h1E);
        chk("ar_cur", 64'(cur_ch), 64'd0);
        chk("ar_flat", sample_flat, 64'd0);
        chk("ar_terr", 64'(timeout_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        drp_drdy = 1'b1;
        drp_do   = 16'hFFF0;
        tick();
        drp_drdy = 1'b0;
        chk("ar_valid", 64'(sample_valid), 64'd0);
        chk("ar_flat2", sample_flat, 64'd0);
        chk("ar_busy2", 64'(busy), 64'd0);
        chk("ar_dens", 64'(den_cnt - d0), 64'd1);

`ifdef XADC_SEQ_AVG_EN
        // 16 reads of ch0, 12'h100..12'h10F, average 12'h107
        ch_en = 4'b0001;
        tick();
        d0 = v0_cnt;
        for (int i = 0; i < 16; i++) begin
            do_read(7'h1E, 0, {12'(12'h100 + i), 4'h0});
            if (i == 14)
                chk("avg_pre", 64'(v0_cnt - d0), 64'd0);
        end
        chk("avg_pulses", 64'(v0_cnt - d0), 64'd1);
        chk("avg_s0", 64'(sample_flat[11:0]), 64'h107);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
